// File: rtl/dcp_pkg.sv
// Shared types and constants for the dcache port arbiter.
// Holds the FSM state, the request owner and the bypass counter sizing.
package dcp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STB_XFER,
        LD_XFER
    } dcp_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_STB,
        OWN_LSU
    } dcp_owner_e;

    localparam int DCP_MAX_BYPASS = 3;
    localparam int DCP_BYP_W      = $clog2(DCP_MAX_BYPASS + 1);

endpackage

// File: rtl/dcache_port_arbiter_bypass_ctr.sv
// dcp_bypass_ctr: saturating count of consecutive load bypasses.
// Ports: clk, rst, inc, clr (wins over inc), limit (count == MAX).
module dcp_bypass_ctr
    import dcp_pkg::*;
#(
    parameter int MAX = DCP_MAX_BYPASS,
    parameter int W   = DCP_BYP_W
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit
);

    localparam logic [W-1:0] LIM = W'(MAX);

    logic [W-1:0] cnt;

    assign limit = (cnt == LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: single dcache port shared by store drain and LSU loads.
// Ports: stb2dcp_* store side, lsu2dcp_*/dcp2lsu_* load side,
//   dcp2dcache_* registered request, dcache2dcp_* completion.
// Optional macro DCP_LD_BYPASS_EN lets loads overtake pending stores
//   (no address hit) up to MAX_BYPASS times in a row.
module dcache_port_arbiter
    import dcp_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = 4,
    parameter int MAX_BYPASS     = DCP_MAX_BYPASS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stb2dcp_req,
    input  logic [ADDR_WIDTH-1:0]     stb2dcp_addr,
    input  logic [DATA_WIDTH-1:0]     stb2dcp_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] stb2dcp_sel_byte,
    input  logic                      stb2dcp_empty,
    output logic                      dcp2stb_ack,
    input  logic                      lsu2dcp_req,
    input  logic [ADDR_WIDTH-1:0]     lsu2dcp_addr,
    input  logic [BYTE_SEL_WIDTH-1:0] lsu2dcp_sel_byte,
    input  logic                      stb2dcp_addr_hit,
    output logic                      dcp2lsu_ack,
    output logic [DATA_WIDTH-1:0]     dcp2lsu_rdata,
    output logic                      dcp2lsu_stall,
    output logic                      dcp2dcache_req,
    output logic                      dcp2dcache_w_en,
    output logic [ADDR_WIDTH-1:0]     dcp2dcache_addr,
    output logic [DATA_WIDTH-1:0]     dcp2dcache_wdata,
    output logic [BYTE_SEL_WIDTH-1:0] dcp2dcache_sel_byte,
    output logic                      dcp2dcache_dmem_sel,
    input  logic                      dcache2dcp_ack,
    input  logic [DATA_WIDTH-1:0]     dcache2dcp_rdata
);

    dcp_state_e state, state_nxt;
    dcp_owner_e owner, owner_nxt;

    logic grant_stb;
    logic grant_lsu;
    logic byp_take;
    logic req_q;

`ifdef DCP_LD_BYPASS_EN
    localparam int CW = $clog2(MAX_BYPASS + 1);

    logic byp_limit;

    // A load may overtake a pending store only when it cannot alias it.
    assign byp_take = stb2dcp_req & lsu2dcp_req
                    & ~stb2dcp_addr_hit & ~byp_limit;

    dcp_bypass_ctr #(
        .MAX (MAX_BYPASS),
        .W   (CW)
    ) u_byp_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (grant_lsu & byp_take),
        .clr   (grant_stb),
        .limit (byp_limit)
    );
`else
    logic unused_addr_hit;

    assign unused_addr_hit = stb2dcp_addr_hit;
    assign byp_take        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWN_NONE;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        grant_stb = 1'b0;
        grant_lsu = 1'b0;
        unique case (state)
            IDLE: begin
                if (byp_take) begin
                    grant_lsu = 1'b1;
                end else if (stb2dcp_req) begin
                    grant_stb = 1'b1;
                end else if (lsu2dcp_req && stb2dcp_empty) begin
                    grant_lsu = 1'b1;
                end
                if (grant_stb) begin
                    state_nxt = STB_XFER;
                    owner_nxt = OWN_STB;
                end else if (grant_lsu) begin
                    state_nxt = LD_XFER;
                    owner_nxt = OWN_LSU;
                end
            end
            STB_XFER, LD_XFER: begin
                if (dcache2dcp_ack) begin
                    state_nxt = IDLE;
                    owner_nxt = OWN_NONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
            end
        endcase
    end

    // Loads leave wdata untouched; it keeps the last store's value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q               <= 1'b0;
            dcp2dcache_w_en     <= 1'b0;
            dcp2dcache_addr     <= '0;
            dcp2dcache_wdata    <= '0;
            dcp2dcache_sel_byte <= '0;
        end else if (grant_stb) begin
            req_q               <= 1'b1;
            dcp2dcache_w_en     <= 1'b1;
            dcp2dcache_addr     <= stb2dcp_addr;
            dcp2dcache_wdata    <= stb2dcp_wdata;
            dcp2dcache_sel_byte <= stb2dcp_sel_byte;
        end else if (grant_lsu) begin
            req_q               <= 1'b1;
            dcp2dcache_w_en     <= 1'b0;
            dcp2dcache_addr     <= lsu2dcp_addr;
            dcp2dcache_sel_byte <= lsu2dcp_sel_byte;
        end else if (state != IDLE && dcache2dcp_ack) begin
            req_q           <= 1'b0;
            dcp2dcache_w_en <= 1'b0;
        end
    end

    assign dcp2dcache_req      = req_q;
    assign dcp2dcache_dmem_sel = req_q;

    // Owner is OWN_NONE in IDLE, so a stray dcache ack reaches nobody.
    assign dcp2stb_ack   = ~rst & (owner == OWN_STB) & dcache2dcp_ack;
    assign dcp2lsu_ack   = ~rst & (owner == OWN_LSU) & dcache2dcp_ack;
    assign dcp2lsu_rdata = dcache2dcp_rdata;
    assign dcp2lsu_stall = ~rst & lsu2dcp_req & ~dcp2lsu_ack;

endmodule
